// File: rtl/rv32_register_file_pkg.sv
// Shared sizing and types for the RV32I integer register file.
// Index and data types are used by the storage block, its interface and its checker.
package register_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/rv32_register_file_if.sv
// Bundle of write-port and read-port signals between the core and the register file.
// The assertion view observes every signal without driving any of them.
interface register_file_intf;
  import register_file_pkg::*;

  logic      wr_en;
  reg_idx_t  wr_reg;
  reg_data_t wr_data;
  reg_idx_t  rd_reg_1;
  reg_idx_t  rd_reg_2;
  reg_data_t rd_data_1;
  reg_data_t rd_data_2;

  modport master (
    output wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2,
    input  rd_data_1, rd_data_2
  );

  modport slave (
    input  wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2,
    output rd_data_1, rd_data_2
  );

  modport assertion (
    input wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2, rd_data_1, rd_data_2
  );

endinterface

// File: rtl/rv32_register_file_sva.sv
// Protocol checker for the register file: x0 reads zero, idle cycles leave reads
// unchanged, and outputs are never unknown outside reset.
module rv32_register_file_sva
  import register_file_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  register_file_intf.assertion bus
);

  logic      seen_q,     seen_d;
  logic      idle_q,     idle_d;
  reg_idx_t  prev_r1_q,  prev_r1_d;
  reg_idx_t  prev_r2_q,  prev_r2_d;
  reg_data_t prev_d1_q,  prev_d1_d;
  reg_data_t prev_d2_q,  prev_d2_d;

  always_comb begin
    seen_d    = 1'b1;
    idle_d    = !bus.wr_en;
    prev_r1_d = bus.rd_reg_1;
    prev_r2_d = bus.rd_reg_2;
    prev_d1_d = bus.rd_data_1;
    prev_d2_d = bus.rd_data_2;
  end

  // seen_q drops on any reset pulse, so a cycle straddling a reset is never compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= 1'b0;
      idle_q    <= 1'b0;
      prev_r1_q <= '0;
      prev_r2_q <= '0;
      prev_d1_q <= '0;
      prev_d2_q <= '0;
    end else begin
      assert (!$isunknown(bus.rd_data_1));
      assert (!$isunknown(bus.rd_data_2));
      if (bus.rd_reg_1 == ZERO_REG) assert (bus.rd_data_1 == '0);
      if (bus.rd_reg_2 == ZERO_REG) assert (bus.rd_data_2 == '0);
      if (seen_q && idle_q && (bus.rd_reg_1 == prev_r1_q)) assert (bus.rd_data_1 == prev_d1_q);
      if (seen_q && idle_q && (bus.rd_reg_2 == prev_r2_q)) assert (bus.rd_data_2 == prev_d2_q);
      seen_q    <= seen_d;
      idle_q    <= idle_d;
      prev_r1_q <= prev_r1_d;
      prev_r2_q <= prev_r2_d;
      prev_d1_q <= prev_d1_d;
      prev_d2_q <= prev_d2_d;
    end
  end

endmodule

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports, one
// synchronous write port, x0 hardwired to zero, no write-to-read bypass.
module rv32_register_file
  import register_file_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  register_file_intf.slave bus
);

  reg_data_t regs_q [NUM_REGS];
  reg_data_t regs_d [NUM_REGS];

  // NOTE: start from the current contents so every path assigns regs_d and no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && (bus.wr_reg != ZERO_REG)) begin
      regs_d[bus.wr_reg] = bus.wr_data;
    end
  end

  // NOTE: the array is reset explicitly because every register must read zero the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so reads in this timestep still see the pre-edge contents.
      regs_q <= regs_d;
    end
  end

  // Entry 0 is never written, but the explicit zero select keeps x0 independent of storage.
  always_comb begin
    bus.rd_data_1 = '0;
    if (bus.rd_reg_1 != ZERO_REG) begin
      bus.rd_data_1 = regs_q[bus.rd_reg_1];
    end
  end

  always_comb begin
    bus.rd_data_2 = '0;
    if (bus.rd_reg_2 != ZERO_REG) begin
      bus.rd_data_2 = regs_q[bus.rd_reg_2];
    end
  end

endmodule

// File: tb/tb_rv32_register_file.sv
// Self-checking bench for rv32_register_file: directed corner cases, then random
// traffic scored against an array model of the architectural registers.
module tb_rv32_register_file;
  import register_file_pkg::*;

  logic clk;
  logic rst_n;

  register_file_intf bus ();

  rv32_register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rv32_register_file_sva u_sva (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] model [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int idx);
    return (idx == 0) ? 32'h0 : model[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic drive(input logic we, input int wreg, input logic [31:0] wdata,
                       input int r1, input int r2);
    bus.wr_en    = we;
    bus.wr_reg   = reg_idx_t'(wreg);
    bus.wr_data  = wdata;
    bus.rd_reg_1 = reg_idx_t'(r1);
    bus.rd_reg_2 = reg_idx_t'(r2);
  endtask

  // Called at a negedge with inputs already driven: commits the edge, returns at the next negedge.
  task automatic cycle();
    @(posedge clk);
    if (bus.wr_en && bus.wr_reg != 0) model[int'(bus.wr_reg)] = bus.wr_data;
    @(negedge clk);
  endtask

  task automatic write_reg(input int idx, input logic [31:0] data);
    drive(1'b1, idx, data, 0, 0);
    cycle();
    drive(1'b0, 0, 32'h0, 0, 0);
  endtask

  task automatic read_check(input string tag, input int r1, input int r2,
                            input logic [31:0] e1, input logic [31:0] e2);
    bus.rd_reg_1 = reg_idx_t'(r1);
    bus.rd_reg_2 = reg_idx_t'(r2);
    #1;
    check({tag, "_p1"}, bus.rd_data_1, e1);
    check({tag, "_p2"}, bus.rd_data_2, e2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    rst_n = 1'b0;
    drive(1'b0, 0, 32'h0, 0, 0);
    #1;
    read_check("reset_x0", 0, 0, 32'h0, 32'h0);
    read_check("reset_x7_x31", 7, 31, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    write_reg(5, 32'hDEADBEEF);
    read_check("x5_after_write", 5, 0, 32'hDEADBEEF, 32'h0);

    write_reg(15, 32'hFFFF0000);
    drive(1'b1, 15, 32'h0000FFFF, 15, 15);
    #1;
    check("x15_no_bypass_p1", bus.rd_data_1, 32'hFFFF0000);
    check("x15_no_bypass_p2", bus.rd_data_2, 32'hFFFF0000);
    cycle();
    drive(1'b0, 0, 32'h0, 15, 15);
    #1;
    check("x15_overwrite_p1", bus.rd_data_1, 32'h0000FFFF);
    check("x15_overwrite_p2", bus.rd_data_2, 32'h0000FFFF);

    write_reg(0, 32'hFFFFFFFF);
    read_check("x0_write_ignored", 0, 0, 32'h0, 32'h0);
    write_reg(3, 32'h12345678);
    write_reg(3, 32'h0);
    read_check("x3_write_zero", 3, 5, 32'h0, 32'hDEADBEEF);

    write_reg(20, 32'hA5A5A5A5);
    drive(1'b0, 20, 32'hFFFFFFFF, 20, 20);
    cycle();
    cycle();
    #1;
    check("x20_wr_en_low_p1", bus.rd_data_1, 32'hA5A5A5A5);
    check("x20_wr_en_low_p2", bus.rd_data_2, 32'hA5A5A5A5);

    // Pulse reset entirely between two rising edges.
    @(negedge clk);
    drive(1'b0, 0, 32'h0, 5, 20);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_x5", bus.rd_data_1, 32'h0);
    check("async_reset_x20", bus.rd_data_2, 32'h0);
    rst_n = 1'b1;
    model_clear();
    read_check("after_reset_x15_x3", 15, 3, 32'h0, 32'h0);
    @(negedge clk);

    for (int n = 0; n < 1000; n++) begin
      logic        we;
      int          wreg, r1, r2;
      logic [31:0] wdata;
      we    = ($urandom_range(0, 3) != 0);
      wreg  = $urandom_range(0, 31);
      wdata = $urandom();
      if ($urandom_range(0, 7) == 0) wdata = 32'h0;
      r1 = $urandom_range(0, 31);
      r2 = ($urandom_range(0, 5) == 0) ? r1 : $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) r1 = wreg;
      drive(we, wreg, wdata, r1, r2);
      #1;
      check($sformatf("rand%0d_p1_x%0d", n, r1), bus.rd_data_1, model_read(r1));
      check($sformatf("rand%0d_p2_x%0d", n, r2), bus.rd_data_2, model_read(r2));
      cycle();
    end

    drive(1'b0, 0, 32'h0, 0, 0);
    for (int i = 1; i < 32; i += 2) begin
      read_check($sformatf("final_x%0d_x%0d", i, i - 1), i, i - 1,
                 model_read(i), model_read(i - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
